// File: rtl/dm_arbiter.sv
// Two-port (CPU / DMA-debug) arbiter and access sequencer for the single-ported data memory.
// Latency: request sampled at edge N, memory access N..N+1, ack pulse N+1..N+2 (3 cycles per transaction).
// Backpressure: requests are held until acked; a request arriving while busy waits and is never dropped.
module dm_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [9:0]  a_addr,
  input  logic [31:0] a_wdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [9:0]  b_addr,
  input  logic [31:0] b_wdata,
  output logic        a_ack,
  output logic        b_ack,
  output logic [31:0] a_rdata,
  output logic [31:0] b_rdata,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q;
  logic        owner_q;       // port that owns the current transaction: 0 = A, 1 = B
  logic        last_grant_q;  // port granted most recently: 0 = A, 1 = B
  logic        we_q;
  logic [9:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] a_rdata_q;
  logic [31:0] b_rdata_q;
  logic        a_ack_q;
  logic        b_ack_q;
  logic        mem_we_q;
  logic        mem_re_q;
  logic        busy_q;

  logic        any_req_d;
  logic        grant_b_d;

  // Pick the winner among the live requests; only consumed in IDLE.
  always_comb begin
    any_req_d = a_req | b_req;
    grant_b_d = b_req;
    if (a_req && b_req) begin
      // On a tie B wins only under round-robin when A was served last.
      grant_b_d = (FIXED_PRIO == 0) && !last_grant_q;
    end
  end

  // Transaction sequencer with all outputs registered; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            owner_q  <= grant_b_d;
            we_q     <= grant_b_d ? b_we    : a_we;
            addr_q   <= grant_b_d ? b_addr  : a_addr;
            wdata_q  <= grant_b_d ? b_wdata : a_wdata;
            mem_we_q <= grant_b_d ? b_we    : a_we;
            mem_re_q <= grant_b_d ? !b_we   : !a_we;
            busy_q   <= 1'b1;
            state_q  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Reads capture the memory output at the closing edge; writes commit in memory here.
          if (!we_q) begin
            if (owner_q) b_rdata_q <= mem_rdata;
            else         a_rdata_q <= mem_rdata;
          end
          mem_we_q <= 1'b0;
          mem_re_q <= 1'b0;
          a_ack_q  <= !owner_q;
          b_ack_q  <= owner_q;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          a_ack_q      <= 1'b0;
          b_ack_q      <= 1'b0;
          busy_q       <= 1'b0;
          last_grant_q <= owner_q;
          state_q      <= S_IDLE;
        end
        default: begin
          a_ack_q  <= 1'b0;
          b_ack_q  <= 1'b0;
          mem_we_q <= 1'b0;
          mem_re_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a round-robin instance and a fixed-priority instance share the request inputs,
// each with its own behavioural memory; a vector table covers single transactions, hand sequences cover
// ties, reset during access and cross-port ordering.
module tb_dm_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;

  // Round-robin instance outputs
  logic        a_ack, b_ack, mem_we, mem_re, busy;
  logic [31:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  // Fixed-priority instance outputs
  logic        f_a_ack, f_b_ack, f_mem_we, f_mem_re, f_busy;
  logic [31:0] f_a_rdata, f_b_rdata, f_mem_wdata, f_mem_rdata;
  logic [9:0]  f_mem_addr;

  logic [31:0] mem_rr [0:1023];
  logic [31:0] mem_fp [0:1023];

  int errors = 0;
  int checks = 0;

  dm_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dm_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_ack(f_a_ack), .b_ack(f_b_ack), .a_rdata(f_a_rdata), .b_rdata(f_b_rdata),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_we(f_mem_we), .mem_re(f_mem_re),
    .mem_rdata(f_mem_rdata), .busy(f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-ported memories: synchronous write, combinational read.
  always @(posedge clk) if (mem_we) mem_rr[mem_addr] <= mem_wdata;
  always @(posedge clk) if (f_mem_we) mem_fp[f_mem_addr] <= f_mem_wdata;
  assign mem_rdata   = mem_rr[mem_addr];
  assign f_mem_rdata = mem_fp[f_mem_addr];

  typedef struct {
    logic        port;      // 0 = A, 1 = B
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata; // requesting port's rdata in the ack cycle
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {17'd0, a_ack, b_ack, busy, mem_we, mem_re, mem_addr, mem_wdata, a_rdata, b_rdata};
  endfunction

  task automatic do_txn(input vec_t v, input int idx);
    @(negedge clk);
    if (!v.port) begin
      a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
    end else begin
      b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d_access", idx), {busy, mem_we, mem_re, a_ack, b_ack, mem_addr},
        {1'b1, v.we, !v.we, 2'b00, v.addr});
    if (v.we) chk($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
    @(posedge clk); #1;
    chk($sformatf("v%0d_ack", idx), {a_ack, b_ack, busy, mem_we, mem_re},
        {!v.port, v.port, 1'b1, 2'b00});
    chk($sformatf("v%0d_rdata", idx), v.port ? b_rdata : a_rdata, v.exp_rdata);
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d_idle", idx), {a_ack, b_ack, busy}, 3'b000);
  endtask

  initial begin
    logic b_done;
    logic got;
    logic [3:0] exp_acks;

    vecs[0] = '{1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 10'h005, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 10'h001, 32'h00000011, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 10'h002, 32'h00000022, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 10'h010, 32'h00000000, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 10'h005, 32'h0,        32'hDEADBEEF};
    vecs[6] = '{1'b0, 1'b0, 10'h002, 32'h0,        32'h00000022};
    vecs[7] = '{1'b1, 1'b1, 10'h000, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[8] = '{1'b0, 1'b0, 10'h000, 32'h0,        32'hCAFEF00D};
    vecs[9] = '{1'b1, 1'b0, 10'h001, 32'h0,        32'h00000011};

    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    #2;
    chk("reset_outputs", all_outs(), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) do_txn(vecs[i], i);

    // Mid-cycle reset clears every output without a clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("midcycle_reset", all_outs(), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset during a write ACCESS aborts the write and suppresses the ack.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h010; a_wdata = 32'hBADBAD00;
    @(posedge clk); #1;
    chk("abort_we_high", {mem_we, mem_addr}, {1'b1, 10'h010});
    #2 rst = 1'b1;
    #1 chk("abort_we_low", {mem_we, busy}, 2'b00);
    a_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_no_ack%0d", i), {a_ack, b_ack}, 2'b00);
    end
    @(negedge clk);
    rst = 1'b0;
    do_txn('{1'b0, 1'b0, 10'h010, 32'h0, 32'h0}, 10);

    // Tie: both ports read continuously; round-robin alternates, fixed priority serves A only.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h001;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h002;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      exp_acks = {(i % 6) == 2, (i % 6) == 5, (i % 3) == 2, 1'b0};
      chk($sformatf("tie_cycle%0d", i), {a_ack, b_ack, f_a_ack, f_b_ack}, exp_acks);
    end
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    chk("tie_rr_rdata", {a_rdata, b_rdata}, {32'h00000011, 32'h00000022});
    chk("tie_fp_a_rdata", f_a_rdata, 32'h00000011);

    // Cross-port coherence: A's read waits behind B's write to the same word.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 10'h3FF; b_wdata = 32'h12345678;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h3FF;
    b_done = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (b_ack) begin
        b_done = 1'b1;
        b_req = 1'b0;
      end
      if (a_ack) begin
        got = 1'b1;
        chk("coh_b_first", b_done, 1'b1);
        chk("coh_a_rdata", a_rdata, 32'h12345678);
        a_req = 1'b0;
        break;
      end
    end
    chk("coh_a_acked", got, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and access sequencer for the single-ported data memory. It shares the memory between the CPU load/store port (A) and a DMA/debug port (B), serialises their requests, and drives the memory's `addr`/`write_data`/`MemWrite`/`MemRead` inputs. The memory's `read_data` is captured into a per-port response register. It sits between the CPU datapath and the data memory, with port B exposed to the debug/DMA fabric.

## Interface
Parameters:
- `FIXED_PRIO`, default 0: 0 selects round-robin between A and B; 1 means A always wins ties.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_req`, `b_req`  in  1  request; held high until the matching ack.
- `a_we`, `b_we`  in  1  1 = write, 0 = read; stable while req is high.
- `a_addr`, `b_addr`  in  10  word address [11:2].
- `a_wdata`, `b_wdata`  in  32  write data.
- `a_ack`, `b_ack`  out  1  one-cycle completion pulse.
- `a_rdata`, `b_rdata`  out  32  read result; valid from the ack cycle and held until the port's next read completes.
- `mem_addr`  out  10  to memory `addr`.
- `mem_wdata`  out  32  to memory `write_data`.
- `mem_we`  out  1  to memory `MemWrite`.
- `mem_re`  out  1  to memory `MemRead`.
- `mem_rdata`  in  32  from memory `read_data`; combinational from `mem_addr`.
- `busy`  out  1  high in ACCESS and RESP states.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high: with `FIXED_PRIO`=1, grant A. With `FIXED_PRIO`=0, grant the port not granted last; `last_grant` resets to B, so A wins the first tie.
  - On a grant, latch the winner's addr/wdata/we, record the winner, and go to ACCESS.
- **ACCESS:**
  - `mem_addr`/`mem_wdata` drive the latched values.
  - `mem_we` = latched we; `mem_re` = !latched we.
  - For a read, `mem_rdata` is captured into the winner's rdata register at the closing edge.
  - For a write, the memory commits at the closing edge and the winner's rdata is unchanged.
  - Go to RESP.
- **RESP:** pulse the winner's ack, update `last_grant`, and go to IDLE. There is no arbitration in this state.
- Requests arriving during ACCESS/RESP wait. A pending request is never dropped.
- Requester protocol: deassert req on the edge that samples ack high, or keep it high to start a new transaction in the following IDLE.
- `mem_addr` and `mem_wdata` keep their last latched values outside ACCESS. `mem_we` and `mem_re` are 0 outside ACCESS.
- Changing addr/we/wdata while req is high and not yet acked is a protocol violation. The latched values are used.

## Timing
- Reset values (asynchronous):
  - State = IDLE, `last_grant` = B.
  - All acks 0, `busy` 0, `mem_we` 0, `mem_re` 0.
  - `mem_addr` 0, `mem_wdata` 0, `a_rdata` 0, `b_rdata` 0.
- Latency: req sampled high at edge N → ACCESS during cycle N..N+1 → ack high during cycle N+1..N+2, with rdata valid in that same cycle. Three cycles per transaction, back-to-back.
- Simultaneous A/B requests in IDLE under round-robin alternate A, B, A, B while both stay high.
- Reset asserted during ACCESS clears `mem_we` immediately. The write is not committed, no ack is issued, and the FSM returns to IDLE.
- Reset during RESP suppresses the ack.
- Write followed by a read of the same address (either port) returns the new data, because the write commits before the next ACCESS.

## Test plan
- Reset: assert `rst` mid-cycle → all outputs 0 with no clock edge; `busy`=0.
- Single write then read on A: write `addr`=0x005, `wdata`=0xDEADBEEF → `a_ack` 2 cycles after the req edge; then read 0x005 → `a_rdata`=0xDEADBEEF on `a_ack`, with `mem_re`=1 only in ACCESS.
- Tie under round-robin: A reads 0x001 and B reads 0x002 continuously, preloaded with 0x11 and 0x22 → grant order A, B, A, B; acks spaced 3 cycles; `b_rdata`=0x22.
- Tie under `FIXED_PRIO`=1 with both requests held for 4 transactions → A acked every time, B never acked.
- Reset during a write ACCESS to 0x010, which holds 0x0 → `mem_we` falls immediately; a later read of 0x010 returns 0x0.
- Cross-port coherence: B writes 0x12345678 to 0x3FF while A's read of 0x3FF is pending behind it → A's `a_rdata`=0x12345678.
